// File: rtl/btn_conditioner.sv
// btn_conditioner: NCH-channel push-button synchroniser, debouncer and auto-repeat generator.
// Optional release pulse on rel is built only when BTN_COND_RELEASE_EN is defined.
module btn_conditioner #(
  parameter int NCH = 4,
  parameter int DB_W = 20,
  parameter int RPT_DLY_W = 26,
  parameter int RPT_W = 24,
  parameter logic [NCH-1:0] PB_INV = '0
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic [NCH-1:0] pb,
  output logic [NCH-1:0] db,
  output logic [NCH-1:0] scen,
  output logic [NCH-1:0] mcen,
  output logic [NCH-1:0] ccen,
  output logic [NCH-1:0] rel
);
  localparam int CW = (DB_W > RPT_DLY_W) ? ((DB_W > RPT_W) ? DB_W : RPT_W)
                                         : ((RPT_DLY_W > RPT_W) ? RPT_DLY_W : RPT_W);
  localparam logic [CW-1:0] DB_MAX  = CW'((64'd1 << DB_W) - 64'd1);
  localparam logic [CW-1:0] DLY_MAX = CW'((64'd1 << RPT_DLY_W) - 64'd1);
  localparam logic [CW-1:0] RPT_MAX = CW'((64'd1 << RPT_W) - 64'd1);
  typedef enum logic [1:0] {IDLE, WAIT_P, HELD, WAIT_R} state_t;
  logic [NCH-1:0] r_s1, r_s2;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= pb ^ PB_INV;
      r_s2 <= r_s1;
    end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t r_state, w_nstate;
    logic [CW-1:0] r_cnt, w_cnt;
    logic r_rpt, w_rpt, w_s, w_hit;
    logic r_db, r_scen, r_mcen, r_ccen, w_db, w_scen, w_mcen, w_ccen;
    assign w_s = r_s2[i];
    assign w_hit = r_cnt == ((r_state == HELD) ? (r_rpt ? RPT_MAX : DLY_MAX) : DB_MAX);
    always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_rpt   <= 1'b0;
        r_db    <= 1'b0;
        r_scen  <= 1'b0;
        r_mcen  <= 1'b0;
        r_ccen  <= 1'b0;
      end else begin
        r_state <= w_nstate;
        r_cnt   <= w_cnt;
        r_rpt   <= w_rpt;
        r_db    <= w_db;
        r_scen  <= w_scen;
        r_mcen  <= w_mcen;
        r_ccen  <= w_ccen;
      end
    // Counter clears on every exit and at every threshold, so it never wraps.
    always_comb begin
      w_nstate = r_state;
      w_cnt    = r_cnt + 1'b1;
      w_rpt    = r_rpt;
      case (r_state)
        IDLE: begin
          w_cnt    = '0;
          w_nstate = w_s ? WAIT_P : IDLE;
        end
        WAIT_P:
          if (!w_s) begin
            w_nstate = IDLE;
            w_cnt    = '0;
          end else if (w_hit) begin
            w_nstate = HELD;
            w_cnt    = '0;
            w_rpt    = 1'b0;
          end
        HELD:
          if (!w_s) begin
            w_nstate = WAIT_R;
            w_cnt    = '0;
          end else if (w_hit) begin
            w_cnt = '0;
            w_rpt = 1'b1;
          end
        default:
          if (w_s) begin
            w_nstate = HELD;
            w_cnt    = '0;
            w_rpt    = 1'b0;
          end else if (w_hit) begin
            w_nstate = IDLE;
            w_cnt    = '0;
          end
      endcase
    end
    always_comb begin
      w_scen = (r_state == WAIT_P) && w_s && w_hit;
      w_mcen = w_scen || ((r_state == HELD) && w_s && w_hit);
      w_db   = (w_nstate == HELD) || (w_nstate == WAIT_R);
      w_ccen = w_nstate == HELD;
    end
    assign db[i]   = r_db;
    assign scen[i] = r_scen;
    assign mcen[i] = r_mcen;
    assign ccen[i] = r_ccen;
`ifdef BTN_COND_RELEASE_EN
    logic r_rel, w_rel;
    assign w_rel = (r_state == WAIT_R) && !w_s && w_hit;
    always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) r_rel <= 1'b0;
      else r_rel <= w_rel;
    assign rel[i] = r_rel;
`else
    assign rel[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus random presses/bounces against a
// run-length based reference model of the button conditioner.
module tb_btn_conditioner;
  localparam int NCH = 2, DB_W = 4, RPT_DLY_W = 6, RPT_W = 5;
  localparam logic [NCH-1:0] INV = 2'b10;
  localparam int QUAL = (1 << DB_W) + 1;
  localparam int FIRST = 1 << RPT_DLY_W;
  localparam int NEXT = 1 << RPT_W;
  logic Clk = 1'b0, Reset_n = 1'b0;
  logic [NCH-1:0] pb = INV;
  logic [NCH-1:0] db, scen, mcen, ccen, rel;
  int n_chk = 0, n_err = 0, ecnt = 0;
  int t0 = 0, scen_edge = -1, scen_cnt = 0, mcen_cnt = 0;
  logic [NCH-1:0] d1, d2, ps, m_db, m_scen, m_mcen, m_ccen, m_rel;
  int run [NCH];
  int age [NCH];
  btn_conditioner #(.NCH(NCH), .DB_W(DB_W), .RPT_DLY_W(RPT_DLY_W), .RPT_W(RPT_W), .PB_INV(INV)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pb(pb), .db(db), .scen(scen), .mcen(mcen), .ccen(ccen), .rel(rel)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, ecnt, got, exp);
    end
  endtask
  // Reference: a press is accepted after QUAL consecutive equal samples; once held,
  // repeats fall FIRST then every NEXT samples after the latest (re)entry into holding.
  always @(posedge Clk) begin
    ecnt++;
    if (!Reset_n) begin
      d1 = '0; d2 = '0; ps = '0; m_db = '0;
      m_scen = '0; m_mcen = '0; m_ccen = '0; m_rel = '0;
      for (int c = 0; c < NCH; c++) begin run[c] = 0; age[c] = 0; end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        logic s;
        s = d2[c]; d2[c] = d1[c]; d1[c] = pb[c] ^ INV[c];
        run[c] = (s == ps[c]) ? run[c] + 1 : 1;
        ps[c] = s;
        m_scen[c] = 1'b0; m_mcen[c] = 1'b0; m_rel[c] = 1'b0;
        if (!m_db[c]) begin
          if (s && run[c] == QUAL) begin
            m_db[c] = 1'b1; m_scen[c] = 1'b1; m_mcen[c] = 1'b1; age[c] = 0;
          end
        end else if (!s) begin
          if (run[c] == QUAL) begin m_db[c] = 1'b0; m_rel[c] = 1'b1; end
        end else if (run[c] == 1) age[c] = 0;
        else begin
          age[c]++;
          if (age[c] >= FIRST && (age[c] - FIRST) % NEXT == 0) m_mcen[c] = 1'b1;
        end
        m_ccen[c] = m_db[c] && s;
      end
    end
  end
  always @(negedge Clk) begin
    chk("db", 32'(db), 32'(m_db));
    chk("scen", 32'(scen), 32'(m_scen));
    chk("mcen", 32'(mcen), 32'(m_mcen));
    chk("ccen", 32'(ccen), 32'(m_ccen));
`ifdef BTN_COND_RELEASE_EN
    chk("rel", 32'(rel), 32'(m_rel));
`else
    chk("rel_off", 32'(rel), 32'd0);
`endif
    if (scen[0]) begin
      scen_cnt++;
      if (scen_edge < 0) scen_edge = ecnt;
    end
    if (mcen[0]) mcen_cnt++;
  end
  task automatic press(input logic [NCH-1:0] p, input int n);
    pb = p ^ INV;
    repeat (n) @(negedge Clk);
  endtask
  initial begin
    repeat (3) @(negedge Clk);
    chk("reset_outs", 32'({db, scen, mcen, ccen, rel}), 32'd0);
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    t0 = ecnt + 1; scen_edge = -1; scen_cnt = 0; mcen_cnt = 0;
    press(2'b01, 200);
    press(2'b00, 40);
    chk("press_lat", 32'(scen_edge - t0), 32'd18);
    chk("press_scen_cnt", 32'(scen_cnt), 32'd1);
    chk("press_mcen_cnt", 32'(mcen_cnt), 32'd5);
    scen_cnt = 0;
    press(2'b01, 10); press(2'b00, 3); press(2'b01, 60); press(2'b00, 40);
    chk("bounce_scen_cnt", 32'(scen_cnt), 32'd1);
    scen_cnt = 0;
    press(2'b01, 30); press(2'b00, 8); press(2'b01, 100); press(2'b00, 40);
    chk("relbounce_scen_cnt", 32'(scen_cnt), 32'd1);
    press(2'b10, 40); press(2'b00, 40);
    press(2'b11, 40); press(2'b00, 40);
    press(2'b01, 50);
    #2 Reset_n = 1'b0;
    #1 chk("async_reset", 32'({db, scen, mcen, ccen, rel}), 32'd0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    t0 = ecnt + 1; scen_edge = -1;
    press(2'b01, 40);
    chk("requal_lat", 32'(scen_edge - t0), 32'd18);
    press(2'b00, 40);
    for (int k = 0; k < 150; k++)
      press(NCH'($urandom_range(0, 3)), $urandom_range(1, 40));
    press(2'b00, 40);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
